alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
Sequencer that sits between the 8-bit pin bus and the alu_8bit instance. It accepts an operation as a short byte stream: an op byte, then operand A, then operand B. It holds registered operands and opcode stable on the ALU inputs, captures the combinational ALU result, and presents it on a valid/ready output. An accumulator allows chained operations, where the previous result becomes operand A.

Parameters:
EXEC_CYCLES, 1, number of cycles operands/opcode are held on the ALU before alu_result is captured; legal range 1..15.
ALLOW_CHAIN, 1, 1 enables accumulator chaining via op-byte bit 4; 0 forces bit 4 to be ignored.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  in_data holds a byte
in_data  input  8  op byte / operand byte stream
in_ready  output  1  controller can accept a byte this cycle
alu_a  output  8  registered operand A to alu_8bit
alu_b  output  8  registered operand B to alu_8bit
alu_op  output  4  registered opcode to alu_8bit
alu_result  input  8  combinational result from alu_8bit
out_valid  output  1  out_data holds a captured result
out_data  output  8  captured result
out_ready  input  1  consumer accepts out_data
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse when an op byte is rejected

Behaviour:
- Reset (rst=0, async): state=IDLE; alu_a, alu_b, out_data, and accumulator acc = 8'h00; alu_op=4'h0; out_valid=0; err=0; exec counter=0.
- Byte transfer: a byte transfers when in_valid && in_ready. in_ready=1 only in IDLE, LOAD_A and LOAD_B. in_ready is combinational from state only and never depends on in_valid.
- Op byte format:
  - [3:0] = opcode.
  - [4] = chain.
  - [7:5] = reserved, must be 0.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, HOLD.
- IDLE, op byte accepted:
  - If [7:5]≠0: byte consumed and discarded, err=1 for the next cycle, stay IDLE, alu_* unchanged.
  - Otherwise alu_op<=[3:0].
    - If chain=1 and ALLOW_CHAIN=1: alu_a<=acc, go to LOAD_B.
    - Else go to LOAD_A.
- LOAD_A: on transfer alu_a<=in_data, go to LOAD_B.
- LOAD_B: on transfer alu_b<=in_data, exec counter<=0, go to EXEC.
- EXEC:
  - in_ready=0.
  - The counter increments each cycle.
  - In the cycle where counter==EXEC_CYCLES-1: out_data<=alu_result, acc<=alu_result, out_valid<=1, go to HOLD.
- HOLD:
  - out_valid=1; out_data and alu_* stay stable.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - No new byte is accepted until IDLE; there is no overlap.
- Latency: the B byte transfers in cycle N; out_valid first goes high in cycle N+1+EXEC_CYCLES. With back-to-back in_valid and out_ready tied high, an unchained op takes 3+EXEC_CYCLES+1 cycles.
- acc updates only on result capture. It keeps its value across idle periods and rejected op bytes. Only reset clears it.
- out_ready asserted outside HOLD has no effect.
- in_valid held high in EXEC/HOLD does not consume the byte; it is taken when in_ready returns.
- Reset during any state aborts the operation immediately. Partial operands are lost and no out_valid is produced.
- ALU width: all 8-bit values wrap mod 256 inside alu_8bit; the controller performs no arithmetic on data.

Test Plan:
- Bench stub: alu_result = alu_a + alu_b mod 256.
- Basic op: stream 8'h03, 8'h12, 8'h34 with EXEC_CYCLES=1 and out_ready=1.
  -> alu_op=4'h3, alu_a=8'h12, alu_b=8'h34.
  -> out_valid for exactly 1 cycle, 2 cycles after the B byte, with out_data=8'h46.
- Chain: after the previous result, stream 8'h15, 8'h0A.
  -> LOAD_A is skipped, alu_a=8'h46, alu_op=4'h5, out_data=8'h50.
  -> With ALLOW_CHAIN=0, the same stream needs a third byte, and 8'h0A is taken as A.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and next op byte 8'h01 presented.
  -> out_data is stable and in_ready=0 throughout.
  -> The op byte is accepted the cycle after the out_ready handshake.
- Reserved bits: op byte 8'hA2 in IDLE.
  -> Byte consumed, err pulses 1 cycle, state stays IDLE, alu_op unchanged, acc unchanged.
- Exec latency: set EXEC_CYCLES=4 and stream 8'h00, 8'hFF, 8'h02.
  -> out_valid rises 5 cycles after the B byte, out_data=8'h01 (wrap), busy is high from op-byte accept to the handshake.
- Reset mid-op: assert rst low asynchronously in LOAD_B (between clock edges).
  -> All outputs are immediately at reset values and acc=8'h00.
  -> After release, a fresh 3-byte stream completes normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Byte-stream sequencer in front of alu_8bit: collects op/A/B bytes, holds them
// on the ALU for EXEC_CYCLES, then presents the captured result on valid/ready.
module alu_seq_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter bit          ALLOW_CHAIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       err,
    output logic [2:0] dbg_state
);

    // Handshakes: a byte moves when in_valid && in_ready; a result moves when
    // out_valid && out_ready. Valid never waits on ready, and in_ready depends
    // on state alone.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] acc_q, acc_d;
    logic       out_valid_q, out_valid_d;
    logic       err_q, err_d;
    logic [3:0] cnt_q, cnt_d;
    logic       xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_op_q    <= 4'h0;
            out_data_q  <= 8'h00;
            acc_q       <= 8'h00;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 4'h0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        in_ready = (state_q == S_IDLE) || (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        out_data_d  = out_data_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    // Reserved bits set: the byte is swallowed and only err reacts.
                    if (|in_data[7:5]) begin
                        err_d = 1'b1;
                    end else begin
                        alu_op_d = in_data[3:0];
                        if (in_data[4] && ALLOW_CHAIN) begin
                            alu_a_d = acc_q;
                            state_d = S_LOAD_B;
                        end else begin
                            state_d = S_LOAD_A;
                        end
                    end
                end
            end
            S_LOAD_A: begin
                if (xfer) begin
                    alu_a_d = in_data;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (xfer) begin
                    alu_b_d = in_data;
                    cnt_d   = 4'h0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    out_data_d  = alu_result;
                    acc_d       = alu_result;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'h1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
